// File: rtl/ls_pkg.sv
// ls_pkg -- shared definitions for the linear-search datapath.
//
// Holds the default address/data widths (shared with the ctu_ls control
// unit) and the scan FSM state encoding used by ls_scan.
//
// Optional build macro used by the importing modules: LS_HIT_CNT_EN.
package ls_pkg;

    // Default address and data widths of the search memory.
    localparam int LS_A = 8;
    localparam int LS_D = 8;

    // Scan FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } ls_state_e;

endpackage

// File: rtl/ls_cmp.sv
// ls_cmp -- compare stage of the linear-search scan.
//
// Delays the issued read address/enable by one cycle so it lines up with
// the returned memory word, compares that word against the latched key,
// and captures the first (lowest) matching address.
//
// Build macro: LS_HIT_CNT_EN adds the hit_cnt output, a saturating count
// of every match seen since the last clear.
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clr         accepted start: clears found/fnd_adr (and hit_cnt)
//   kill        discard the read issued this cycle (first-hit abort)
//   rd_ce       read enable issued this cycle
//   rd_adr      read address issued this cycle
//   mem_dat     memory data for the read issued last cycle
//   key         latched search key
//   hit         combinational: returned word is valid and equals key
//   found       a match has been captured since the last clear
//   fnd_adr     address of the first captured match
//   hit_cnt     (LS_HIT_CNT_EN only) number of matches, saturating at 2^A
module ls_cmp
    import ls_pkg::*;
#(
    parameter int A = LS_A,
    parameter int D = LS_D
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         kill,
    input  logic         rd_ce,
    input  logic [A-1:0] rd_adr,
    input  logic [D-1:0] mem_dat,
    input  logic [D-1:0] key,
    output logic         hit,
    output logic         found,
    output logic [A-1:0] fnd_adr
`ifdef LS_HIT_CNT_EN
    ,
    output logic [A:0]   hit_cnt
`endif
);

    logic         vld_r;
    logic [A-1:0] dly_adr_r;

    // Match detection on the word returned for last cycle's read.
    always_comb begin
        hit = vld_r && (mem_dat == key);
    end

    // One-cycle address/valid pipeline aligned with the memory read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_r     <= 1'b0;
            dly_adr_r <= {A{1'b0}};
        end else begin
            // A read issued in the abort cycle must not be compared later.
            vld_r     <= rd_ce & ~kill;
            dly_adr_r <= rd_adr;
        end
    end

    // First-match capture; later matches never overwrite the lowest address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            found   <= 1'b0;
            fnd_adr <= {A{1'b0}};
        end else if (clr) begin
            found   <= 1'b0;
            fnd_adr <= {A{1'b0}};
        end else if (hit && !found) begin
            found   <= 1'b1;
            fnd_adr <= dly_adr_r;
        end else begin
            found   <= found;
            fnd_adr <= fnd_adr;
        end
    end

`ifdef LS_HIT_CNT_EN
    localparam logic [A:0] CNT_MAX = {1'b1, {A{1'b0}}};
    localparam logic [A:0] CNT_ONE = {{A{1'b0}}, 1'b1};

    // Saturating count of all matches in the scanned range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt <= {(A+1){1'b0}};
        end else if (clr) begin
            hit_cnt <= {(A+1){1'b0}};
        end else if (hit && (hit_cnt != CNT_MAX)) begin
            hit_cnt <= hit_cnt + CNT_ONE;
        end else begin
            hit_cnt <= hit_cnt;
        end
    end
`endif

endmodule

// File: rtl/ls_scan.sv
// ls_scan -- linear-search scan datapath downstream of ctu_ls.
//
// On an accepted start the range bounds are ordered (str = min, end = max)
// and latched with the key; the block then reads str..end from a
// synchronous memory, one address per cycle, and reports found / fnd_adr
// with a one-cycle done pulse. By default the scan stops at the first hit.
//
// Build macro: LS_HIT_CNT_EN -- adds hit_cnt and always scans the whole
// range (fnd_adr still reports the lowest match).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               search request, honoured only when idle
//   sch_adr1, sch_adr2  range bounds, in either order
//   sch_key             value to search for
//   mem_dat             read data, valid the cycle after mem_ce
//   mem_adr, mem_ce     memory read address / enable
//   busy                scan in progress
//   done                one-cycle completion pulse
//   found, fnd_adr      result of the last scan
//   hit_cnt             (LS_HIT_CNT_EN only) matches in the range
module ls_scan
    import ls_pkg::*;
#(
    parameter int A = LS_A,
    parameter int D = LS_D
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [A-1:0] sch_adr1,
    input  logic [A-1:0] sch_adr2,
    input  logic [D-1:0] sch_key,
    input  logic [D-1:0] mem_dat,
    output logic [A-1:0] mem_adr,
    output logic         mem_ce,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [A-1:0] fnd_adr
`ifdef LS_HIT_CNT_EN
    ,
    output logic [A:0]   hit_cnt
`endif
);

    localparam logic [A-1:0] ADR_ONE = {{(A-1){1'b0}}, 1'b1};

    ls_state_e    state_r;
    logic [A-1:0] end_r;
    logic [D-1:0] key_r;
    logic [A-1:0] lo_s;
    logic [A-1:0] hi_s;
    logic         clr_s;
    logic         hit_s;
    logic         abort_s;

    // Order the requested bounds so the scan always walks upward.
    always_comb begin
        if (sch_adr1 <= sch_adr2) begin
            lo_s = sch_adr1;
            hi_s = sch_adr2;
        end else begin
            lo_s = sch_adr2;
            hi_s = sch_adr1;
        end
    end

    // Start acceptance and first-hit abort decode.
    always_comb begin
        clr_s = (state_r == ST_IDLE) && start;
`ifdef LS_HIT_CNT_EN
        abort_s = 1'b0;
`else
        abort_s = (state_r == ST_SCAN) && hit_s;
`endif
    end

    // Scan FSM and address counter; all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            mem_adr <= {A{1'b0}};
            mem_ce  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            end_r   <= {A{1'b0}};
            key_r   <= {D{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mem_adr <= lo_s;
                        end_r   <= hi_s;
                        key_r   <= sch_key;
                        mem_ce  <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= ST_SCAN;
                    end else begin
                        mem_ce  <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (abort_s) begin
                        mem_ce  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (mem_adr == end_r) begin
                        // Stop on equality rather than overflow so end = 2^A-1
                        // never wraps back to address 0.
                        mem_ce  <= 1'b0;
                        done    <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else begin
                        mem_adr <= mem_adr + ADR_ONE;
                        done    <= 1'b0;
                        state_r <= ST_SCAN;
                    end
                end
                ST_DRAIN: begin
                    // Last word is compared this cycle by ls_cmp.
                    mem_ce  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_ce  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    ls_cmp #(
        .A (A),
        .D (D)
    ) u_cmp (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_s),
        .kill    (abort_s),
        .rd_ce   (mem_ce),
        .rd_adr  (mem_adr),
        .mem_dat (mem_dat),
        .key     (key_r),
        .hit     (hit_s),
        .found   (found),
        .fnd_adr (fnd_adr)
`ifdef LS_HIT_CNT_EN
        ,
        .hit_cnt (hit_cnt)
`endif
    );

endmodule
